bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Initiator (master) side of the single-byte shared-bus memory protocol (enable / rw / bidirectional bus) used by the 256-byte RAM responder.
- Accepts host read/write requests on a valid/ready interface and sequences the address, data and turnaround phases on the shared bus.
- Returns read data on a one-cycle response strobe.
- Sits between the CPU datapath/controller and the RAM.

Parameters:
- BITW, 8, width of bus, address and data; address space is 2**BITW bytes.

Ports:
- clock  input  1  system clock, all logic on posedge
- n_reset  input  1  asynchronous active-low reset
- req_valid  input  1  host request present
- req_ready  output  1  request accepted at posedge when req_valid && req_ready
- req_we  input  1  1 = write, 0 = read
- req_addr  input  BITW  target address
- req_wdata  input  BITW  write data
- resp_valid  output  1  one-cycle completion pulse (reads and writes)
- resp_we  output  1  type of the completed transaction
- resp_rdata  output  BITW  read data; valid with resp_valid && !resp_we
- enable  output  1  bus enable to responder
- rw  output  1  bus direction to responder (0 read, 1 write)
- bus  inout  BITW  shared bus; driven through an internal drive-enable, high-Z otherwise

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE; enable=0, rw=0, bus released (Z); req_ready=1.
  - resp_valid=0, resp_we=0, resp_rdata=0.
  - Held address/data registers cleared to 0.
- Registered outputs: enable, rw, bus drive value and bus drive-enable all come from flops; no combinational path from req_* to the bus.
- States: IDLE, ADDR, WDATA, RWAIT, RSAMPLE.
- IDLE: enable=0, bus released. On accept, latch req_we/req_addr/req_wdata and go to ADDR.
- ADDR (1 cycle): enable=1, rw=req_we, bus=addr. Next state is WDATA if write, else RWAIT.
- WDATA (1 cycle): enable=1, rw=1, bus=wdata; the responder writes memory at the end of this cycle.
- RWAIT (1 cycle): enable=1, rw=0, bus released; the responder loads read data at the end of this cycle.
- RSAMPLE (1 cycle): enable=0, rw=0, bus released; the responder drives the bus. Sample bus into resp_rdata at the posedge ending RSAMPLE.
  - enable must be 0 here; otherwise the responder latches its own data as an address.
- Latency (accept to first bus phase): bus phase ADDR begins the cycle after accept.
  - Write: 2 bus cycles, resp_valid 1 cycle after WDATA.
  - Read: 3 bus cycles, resp_valid and resp_rdata 1 cycle after RSAMPLE.
- req_ready=1 in IDLE, WDATA and RSAMPLE; 0 in ADDR and RWAIT.
  - An accept in WDATA/RSAMPLE goes straight to ADDR (back-to-back, no idle cycle).
  - Throughput: write 2 cycles/txn, read 3 cycles/txn.
- Completion with no pending request: go to IDLE.
- Bus contention rules:
  - Never drive the bus in RWAIT or RSAMPLE.
  - The responder releases the bus at the end of RSAMPLE, so driving ADDR in the following cycle is legal.
- resp_valid: single-cycle pulse per transaction, never asserted two cycles in a row except for back-to-back completions.
- resp_rdata holds the last read value; writes do not change it.
- req_* are ignored when req_ready=0; the host must hold them stable until accepted.
- Reset mid-transaction:
  - Outputs return to reset values immediately (async); the in-flight transaction is dropped and no resp_valid is issued.
  - Initiator and responder share n_reset at system level.
- Address wrap: addr is BITW bits; no arithmetic is performed. 0xFF is a legal address.

Test Plan:
- Write 0x5A to 0x10 (bench responder model) -> ADDR cycle: enable=1,rw=1,bus=0x10; WDATA cycle: bus=0x5A; resp_valid=1,resp_we=1 next cycle; model mem[0x10]=0x5A.
- Read 0x10 after above -> ADDR bus=0x10,rw=0; RWAIT bus Z, enable=1; RSAMPLE enable=0; resp_valid=1,resp_we=0,resp_rdata=0x5A exactly 4 cycles after accept.
- Back-to-back with req_valid held high: write 0xFF->0x00, read 0x00, read 0xFF (returns reset 0x00), write 0x01->0xFF.
  - Required response: accepts at 2/3-cycle spacing, no idle gaps, bench checks no bus contention (no X on bus) and resp_rdata sequence 0xFF, 0x00.
- Backpressure: assert req_valid during ADDR/RWAIT with changing req_addr -> request not accepted until req_ready=1; the latched address equals the value at the accepting edge.
- Async reset asserted mid-RWAIT -> enable=0, bus Z, req_ready=1, resp_valid=0 within the same cycle; no resp_valid after release; subsequent read 0x10 returns 0x00.
- Idle: req_valid=0 for 10 cycles -> enable=0, bus Z, resp_valid=0 throughout.

Source files
------------

// File: rtl/bus_initiator.sv
// Initiator side of the enable/rw shared-bus RAM protocol: turns host valid/ready
// requests into address, write-data and read-turnaround phases on the bus.
module bus_initiator #(
    parameter int BITW = 8
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [BITW-1:0] req_addr,
    input  logic [BITW-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_we,
    output logic [BITW-1:0] resp_rdata,
    output logic            enable,
    output logic            rw,
    inout  wire  [BITW-1:0] bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] WDATA   = 3'd2;
    localparam logic [2:0] RWAIT   = 3'd3;
    localparam logic [2:0] RSAMPLE = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic            we_hold;
    logic [BITW-1:0] wdata_hold;
    logic            drive_en;
    logic [BITW-1:0] drive_val;
    logic            accept;

    // WDATA and RSAMPLE are final phases, so a new request may start ADDR right after them.
    assign req_ready = (state == IDLE) || (state == WDATA) || (state == RSAMPLE);
    assign accept    = req_valid && req_ready;
    assign bus       = drive_en ? drive_val : {BITW{1'bz}};

    always_comb begin
        state_next = state;
        case (state)
            IDLE, WDATA, RSAMPLE: state_next = accept ? ADDR : IDLE;
            ADDR:                 state_next = we_hold ? WDATA : RWAIT;
            RWAIT:                state_next = RSAMPLE;
            default:              state_next = IDLE;
        endcase
    end

    // Bus-facing outputs are decoded from the next state so each phase starts on a clean edge.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            we_hold    <= 1'b0;
            wdata_hold <= '0;
            drive_en   <= 1'b0;
            drive_val  <= '0;
            enable     <= 1'b0;
            rw         <= 1'b0;
            resp_valid <= 1'b0;
            resp_we    <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_hold    <= req_we;
                wdata_hold <= req_wdata;
            end
            case (state_next)
                ADDR: begin
                    enable    <= 1'b1;
                    rw        <= req_we;
                    drive_en  <= 1'b1;
                    drive_val <= req_addr;
                end
                WDATA: begin
                    enable    <= 1'b1;
                    rw        <= 1'b1;
                    drive_en  <= 1'b1;
                    drive_val <= wdata_hold;
                end
                RWAIT: begin
                    enable   <= 1'b1;
                    rw       <= 1'b0;
                    drive_en <= 1'b0;
                end
                default: begin
                    // RSAMPLE must drop enable or the responder would take its own data as an address.
                    enable   <= 1'b0;
                    rw       <= 1'b0;
                    drive_en <= 1'b0;
                end
            endcase
            resp_valid <= (state == WDATA) || (state == RSAMPLE);
            resp_we    <= (state == WDATA);
            if (state == RSAMPLE) begin
                resp_rdata <= bus;
            end
        end
    end
endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a behavioural 256-byte RAM responder on the shared bus.
module tb_bus_initiator;
    logic       clock = 1'b0;
    logic       n_reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_we;
    logic [7:0] resp_rdata;
    logic       enable;
    logic       rw;
    wire  [7:0] bus;

    logic       resp_drive;
    logic [7:0] resp_val;
    logic       probe_en = 1'b0;
    logic [7:0] probe_val = 8'h00;
    logic [7:0] mem [0:255];
    logic [1:0] ph;
    logic [7:0] raddr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bus_initiator #(.BITW(8)) dut (
        .clock(clock), .n_reset(n_reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
        .enable(enable), .rw(rw), .bus(bus)
    );

    assign bus = resp_drive ? resp_val : (probe_en ? probe_val : 8'hzz);

    always #5 clock = ~clock;

    // Responder: latch address on enable, write at end of the data phase,
    // load read data at end of the turnaround phase and drive it for one cycle.
    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            ph <= 2'd0;
            resp_drive <= 1'b0;
            resp_val <= 8'h00;
            raddr <= 8'h00;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            case (ph)
                2'd0: if (enable) begin
                    raddr <= bus;
                    ph <= rw ? 2'd1 : 2'd2;
                end
                2'd1: begin
                    mem[raddr] <= bus;
                    ph <= 2'd0;
                end
                2'd2: begin
                    resp_val <= mem[raddr];
                    resp_drive <= 1'b1;
                    ph <= 2'd3;
                end
                default: begin
                    resp_drive <= 1'b0;
                    ph <= 2'd0;
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Drives two patterns onto the bus; both read back only if no one else drives it.
    task automatic probe(output logic released);
        probe_en = 1'b1;
        probe_val = 8'hA5;
        #1;
        released = (bus === 8'hA5);
        probe_val = 8'h5A;
        #1;
        released = released && (bus === 8'h5A);
        probe_en = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic rel;
        #2 n_reset = 1'b0;
        tick();
        checks++;
        if ({enable, rw, req_ready, resp_valid, resp_we} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_ctrl: got en/rw/rdy/rv/rwe=%b expected 00100",
                     {enable, rw, req_ready, resp_valid, resp_we});
        end
        checks++;
        if (resp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 00", resp_rdata);
        end
        probe(rel);
        checks++;
        if (rel !== 1'b1) begin
            failures++;
            $display("FAIL reset_bus_released: got released=%b expected 1", rel);
        end
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_write;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h5A;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready_idle: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({enable, rw, req_ready, bus} !== {3'b110, 8'h10}) begin
            failures++;
            $display("FAIL wr_addr_phase: got en/rw/rdy=%b bus=%h expected 110 bus=10",
                     {enable, rw, req_ready}, bus);
        end
        tick();
        checks++;
        if ({enable, rw, req_ready, resp_valid, bus} !== {4'b1110, 8'h5A}) begin
            failures++;
            $display("FAIL wr_data_phase: got en/rw/rdy/rv=%b bus=%h expected 1110 bus=5a",
                     {enable, rw, req_ready, resp_valid}, bus);
        end
        tick();
        checks++;
        if ({resp_valid, resp_we, enable} !== 3'b110) begin
            failures++;
            $display("FAIL wr_resp: got rv/rwe/en=%b expected 110", {resp_valid, resp_we, enable});
        end
        checks++;
        if (mem[8'h10] !== 8'h5A) begin
            failures++;
            $display("FAIL wr_mem: got mem[10]=%h expected 5a", mem[8'h10]);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp_pulse: got %b expected 0", resp_valid);
        end
    endtask

    task automatic test_read;
        logic rel;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({enable, rw, req_ready, bus} !== {3'b100, 8'h10}) begin
            failures++;
            $display("FAIL rd_addr_phase: got en/rw/rdy=%b bus=%h expected 100 bus=10",
                     {enable, rw, req_ready}, bus);
        end
        tick();
        checks++;
        if ({enable, rw, req_ready} !== 3'b100) begin
            failures++;
            $display("FAIL rd_wait_phase: got en/rw/rdy=%b expected 100", {enable, rw, req_ready});
        end
        probe(rel);
        checks++;
        if (rel !== 1'b1) begin
            failures++;
            $display("FAIL rd_wait_released: got released=%b expected 1", rel);
        end
        tick();
        checks++;
        if ({enable, rw, req_ready, resp_valid, bus} !== {4'b0010, 8'h5A}) begin
            failures++;
            $display("FAIL rd_sample_phase: got en/rw/rdy/rv=%b bus=%h expected 0010 bus=5a",
                     {enable, rw, req_ready, resp_valid}, bus);
        end
        tick();
        checks++;
        if ({resp_valid, resp_we, resp_rdata} !== {2'b10, 8'h5A}) begin
            failures++;
            $display("FAIL rd_resp: got rv/rwe=%b rdata=%h expected 10 rdata=5a",
                     {resp_valid, resp_we}, resp_rdata);
        end
        tick();
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL rd_hold: got rv=%b rdata=%h expected 0 rdata=5a", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic       twe [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] tad [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] tdt [4] = '{8'hFF, 8'h00, 8'h00, 8'h01};
        int         acc [4] = '{0, 0, 0, 0};
        logic [7:0] rd [$];
        logic [3:0] wes;
        int         idx = 0;
        req_we = twe[0]; req_addr = tad[0]; req_wdata = tdt[0]; req_valid = 1'b1;
        for (int n = 0; n < 40 && rd.size() < 4; n++) begin
            if (idx < 4 && req_ready) begin
                acc[idx] = cyc;
                idx++;
            end
            tick();
            if (idx < 4) begin
                req_we = twe[idx]; req_addr = tad[idx]; req_wdata = tdt[idx];
            end else begin
                req_valid = 1'b0;
            end
            if (resp_valid) begin
                rd.push_back(resp_rdata);
                wes = {wes[2:0], resp_we};
            end
        end
        req_valid = 1'b0;
        checks++;
        if (rd.size() != 4) begin
            failures++;
            $display("FAIL b2b_resp_count: got %0d expected 4", rd.size());
        end else begin
            checks++;
            if ({acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]} !== {32'd2, 32'd3, 32'd3}) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d %0d %0d expected 2 3 3",
                         acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
            end
            checks++;
            if (wes !== 4'b1001) begin
                failures++;
                $display("FAIL b2b_resp_we: got %b expected 1001", wes);
            end
            checks++;
            if ({rd[1], rd[2]} !== {8'hFF, 8'h00}) begin
                failures++;
                $display("FAIL b2b_rdata: got %h %h expected ff 00", rd[1], rd[2]);
            end
        end
        checks++;
        if ({mem[8'h00], mem[8'hFF]} !== {8'hFF, 8'h01}) begin
            failures++;
            $display("FAIL b2b_mem: got mem[00]=%h mem[ff]=%h expected ff 01", mem[8'h00], mem[8'hFF]);
        end
        tick();
    endtask

    task automatic test_backpressure;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_addr = 8'h20;
        checks++;
        if ({req_ready, bus} !== {1'b0, 8'h10}) begin
            failures++;
            $display("FAIL bp_addr_phase: got rdy=%b bus=%h expected 0 bus=10", req_ready, bus);
        end
        tick();
        req_addr = 8'h30;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_wait_ready: got %b expected 0", req_ready);
        end
        tick();
        req_addr = 8'h44;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_sample_ready: got %b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({enable, rw, bus, resp_valid, resp_rdata} !== {2'b10, 8'h44, 1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL bp_accept: got en/rw=%b bus=%h rv=%b rdata=%h expected 10 44 1 5a",
                     {enable, rw}, bus, resp_valid, resp_rdata);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({resp_valid, resp_rdata} !== {1'b1, 8'h00}) begin
            failures++;
            $display("FAIL bp_second_read: got rv=%b rdata=%h expected 1 00", resp_valid, resp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        logic rel;
        int   seen = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if ({enable, rw} !== 2'b10) begin
            failures++;
            $display("FAIL rst_pre_rwait: got en/rw=%b expected 10", {enable, rw});
        end
        n_reset = 1'b0;
        #1;
        checks++;
        if ({enable, rw, req_ready, resp_valid, resp_rdata} !== {4'b0010, 8'h00}) begin
            failures++;
            $display("FAIL rst_async: got en/rw/rdy/rv=%b rdata=%h expected 0010 00",
                     {enable, rw, req_ready, resp_valid}, resp_rdata);
        end
        probe(rel);
        checks++;
        if (rel !== 1'b1) begin
            failures++;
            $display("FAIL rst_bus_released: got released=%b expected 1", rel);
        end
        tick();
        tick();
        n_reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (resp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_no_resp: got %0d responses expected 0", seen);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({resp_valid, resp_we, resp_rdata} !== {2'b10, 8'h00}) begin
            failures++;
            $display("FAIL rst_read_after: got rv/rwe=%b rdata=%h expected 10 00",
                     {resp_valid, resp_we}, resp_rdata);
        end
        tick();
    endtask

    task automatic test_idle;
        logic rel;
        int   busy = 0;
        int   held = 0;
        req_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (enable || resp_valid) busy++;
            probe(rel);
            if (!rel) held++;
        end
        checks++;
        if (busy != 0) begin
            failures++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", busy);
        end
        checks++;
        if (held != 0) begin
            failures++;
            $display("FAIL idle_bus_released: got %0d driven cycles expected 0", held);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
